// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: DC->MEM payload register, variable-latency load response FSM
// and load data extraction. Define MEM_STAGE_FWD_EN to add the MEM-stage forwarding outputs.
module mem_stage_lsu #(
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int STALL_W   = 7,
  parameter int STAGE     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [STALL_W-1:0]   stall,
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 ram_en_i,
  input  logic [3:0]           ram_wen_i,
  input  logic [2:0]           load_type_i,
  input  logic                 sel_rf_res_i,
  input  logic                 rf_we_i,
  input  logic [RF_ADDR_W-1:0] rf_waddr_i,
  input  logic [31:0]          alu_result_i,
  input  logic                 data_ok,
  input  logic [31:0]          data_rdata,
  output logic                 stallreq_mem,
  output logic [PC_W-1:0]      wb_pc,
  output logic                 wb_rf_we,
  output logic [RF_ADDR_W-1:0] wb_rf_waddr,
  output logic [31:0]          wb_rf_wdata
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic                 mem_fwd_we,
  output logic [RF_ADDR_W-1:0] mem_fwd_waddr,
  output logic [31:0]          mem_fwd_wdata,
  output logic                 mem_fwd_load_pending
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic                 advance;
  logic                 bubble;
  logic                 load_cap;
  logic                 unused_stall;

  logic [PC_W-1:0]      pc_q;
  logic [2:0]           load_type_q;
  logic                 sel_q;
  logic                 rf_we_q;
  logic [RF_ADDR_W-1:0] waddr_q;
  logic [31:0]          alu_q;

  logic [1:0]           state_q, state_d;
  logic [31:0]          buf_q, buf_d;
  logic                 pend_q, pend_d;

  logic [31:0]          raw;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [31:0]          ext;
  logic                 load_waiting;

  assign advance      = ~stall[STAGE];
  assign bubble       = stall[STAGE] & ~stall[STAGE+1];
  assign load_cap     = advance & ~flush & ram_en_i & (ram_wen_i == 4'b0000);
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      pc_q        <= '0;
      load_type_q <= '0;
      sel_q       <= 1'b0;
      rf_we_q     <= 1'b0;
      waddr_q     <= '0;
      alu_q       <= '0;
    end else if (advance) begin
      pc_q        <= pc_i;
      load_type_q <= load_type_i;
      sel_q       <= sel_rf_res_i;
      rf_we_q     <= rf_we_i;
      waddr_q     <= rf_waddr_i;
      alu_q       <= alu_result_i;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pend_d  = 1'b0;
    case (state_q)
      S_IDLE: if (load_cap) state_d = S_WAIT;
      S_WAIT: begin
        if (flush) begin
          state_d = data_ok ? S_IDLE : S_DRAIN;
        end else if (data_ok) begin
          if (advance) begin
            state_d = load_cap ? S_WAIT : S_IDLE;
          end else begin
            buf_d   = data_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush || bubble) state_d = S_IDLE;
        else if (advance)    state_d = load_cap ? S_WAIT : S_IDLE;
      end
      S_DRAIN: begin
        // pend_q marks a load captured while the stale response is still in flight
        if (data_ok) state_d = ((pend_q & ~flush) | load_cap) ? S_WAIT : S_IDLE;
        else         pend_d  = ~flush & (pend_q | load_cap);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    raw    = (state_q == S_HOLD) ? buf_q : data_rdata;
    byte_v = raw[{alu_q[1:0], 3'b000} +: 8];
    half_v = raw[{alu_q[1], 4'b0000} +: 16];
    case (load_type_q)
      3'd1:    ext = {{24{byte_v[7]}}, byte_v};
      3'd2:    ext = {24'b0, byte_v};
      3'd3:    ext = {{16{half_v[15]}}, half_v};
      3'd4:    ext = {16'b0, half_v};
      default: ext = raw;
    endcase
  end

  assign load_waiting = (state_q == S_WAIT) & ~data_ok;
  assign stallreq_mem = load_waiting;
  assign wb_pc        = pc_q;
  assign wb_rf_we     = rf_we_q & ~load_waiting;
  assign wb_rf_waddr  = waddr_q;
  assign wb_rf_wdata  = sel_q ? ext : alu_q;

`ifdef MEM_STAGE_FWD_EN
  assign mem_fwd_we           = wb_rf_we;
  assign mem_fwd_waddr        = wb_rf_waddr;
  assign mem_fwd_wdata        = wb_rf_wdata;
  assign mem_fwd_load_pending = load_waiting;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; inputs change 1 ns after the
// rising edge and outputs are checked 1 ns later.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [6:0]  ext_stall;
  logic [6:0]  stall;
  logic [31:0] pc_i;
  logic        ram_en_i;
  logic [3:0]  ram_wen_i;
  logic [2:0]  load_type_i;
  logic        sel_rf_res_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] alu_result_i;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        stallreq_mem;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
`ifdef MEM_STAGE_FWD_EN
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
  logic        mem_fwd_load_pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // The stage freezes the whole pipe while it requests a stall.
  assign stall = ext_stall | {7{stallreq_mem}};

  always #5 clk = ~clk;

  mem_stage_lsu #(.PC_W(32), .RF_ADDR_W(5), .STALL_W(7), .STAGE(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .pc_i(pc_i),
    .ram_en_i(ram_en_i), .ram_wen_i(ram_wen_i), .load_type_i(load_type_i),
    .sel_rf_res_i(sel_rf_res_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .alu_result_i(alu_result_i), .data_ok(data_ok), .data_rdata(data_rdata),
    .stallreq_mem(stallreq_mem), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata)
`ifdef MEM_STAGE_FWD_EN
    , .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
    .mem_fwd_wdata(mem_fwd_wdata), .mem_fwd_load_pending(mem_fwd_load_pending)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_nop();
    pc_i = '0; ram_en_i = 1'b0; ram_wen_i = '0; load_type_i = '0;
    sel_rf_res_i = 1'b0; rf_we_i = 1'b0; rf_waddr_i = '0; alu_result_i = '0;
  endtask

  task automatic drive_load(input logic [31:0] pc, input logic [2:0] lt,
                            input logic [4:0] rd, input logic [31:0] addr);
    pc_i = pc; ram_en_i = 1'b1; ram_wen_i = 4'b0000; load_type_i = lt;
    sel_rf_res_i = 1'b1; rf_we_i = 1'b1; rf_waddr_i = rd; alu_result_i = addr;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
    pc_i = pc; ram_en_i = 1'b0; ram_wen_i = 4'b0000; load_type_i = '0;
    sel_rf_res_i = 1'b0; rf_we_i = 1'b1; rf_waddr_i = rd; alu_result_i = res;
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1] = '{3'd2, 32'h0000_1001, 32'h0000_F500, 32'h0000_00F5};
    vecs[2] = '{3'd3, 32'h0000_0000, 32'h1234_8001, 32'hFFFF_8001};
    vecs[3] = '{3'd3, 32'h0000_0003, 32'h7FFF_0000, 32'h0000_7FFF};
    vecs[4] = '{3'd0, 32'h0000_0008, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[5] = '{3'd7, 32'h0000_0002, 32'h0102_0304, 32'h0102_0304};
    vecs[6] = '{3'd1, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F};

    rst = 1'b1; flush = 1'b0; ext_stall = '0; data_ok = 1'b0; data_rdata = '0;
    drive_nop();
    tick(); tick();
    chk("rst_stallreq", {31'b0, stallreq_mem}, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    chk("rst_we", {31'b0, wb_rf_we}, 32'd0);
    chk("rst_waddr", {27'b0, wb_rf_waddr}, 32'd0);
    chk("rst_wdata", wb_rf_wdata, 32'd0);
    rst = 1'b0;

    // Loads answered in their first MEM cycle: no stall, extraction checked.
    foreach (vecs[i]) begin
      drive_load(32'h100 + 4 * i, vecs[i].lt, 5'd3, vecs[i].addr);
      tick();
      drive_nop();
      data_ok = 1'b1; data_rdata = vecs[i].rdata;
      settle();
      chk($sformatf("fast%0d_stallreq", i), {31'b0, stallreq_mem}, 32'd0);
      chk($sformatf("fast%0d_we", i), {31'b0, wb_rf_we}, 32'd1);
      chk($sformatf("fast%0d_wdata", i), wb_rf_wdata, vecs[i].exp);
      tick();
      data_ok = 1'b0; data_rdata = '0;
    end
    chk("fast_pc_after", wb_pc, 32'd0);

    // LHU answered three cycles late.
    drive_load(32'h200, 3'd4, 5'd4, 32'h0000_2002);
    tick();
    drive_nop();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("lhu_stall_c%0d", c), {31'b0, stallreq_mem}, 32'd1);
      chk($sformatf("lhu_we_c%0d", c), {31'b0, wb_rf_we}, 32'd0);
      tick();
    end
    data_ok = 1'b1; data_rdata = 32'hBEEF_0001;
    settle();
    chk("lhu_stall_done", {31'b0, stallreq_mem}, 32'd0);
    chk("lhu_we", {31'b0, wb_rf_we}, 32'd1);
    chk("lhu_waddr", {27'b0, wb_rf_waddr}, 32'd4);
    chk("lhu_pc", wb_pc, 32'h200);
    chk("lhu_wdata", wb_rf_wdata, 32'h0000_BEEF);
    tick();
    data_ok = 1'b0; data_rdata = '0;

    // Response arrives while frozen by another source: buffered in HOLD.
    drive_load(32'h300, 3'd0, 5'd7, 32'h0000_3000);
    tick();
    drive_nop();
    ext_stall = 7'b1100000;
    settle();
    chk("hold_wait_stall", {31'b0, stallreq_mem}, 32'd1);
    tick();
    data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    tick();
    data_ok = 1'b0; data_rdata = '0;
    settle();
    chk("hold_stallreq", {31'b0, stallreq_mem}, 32'd0);
    chk("hold_wdata", wb_rf_wdata, 32'hDEAD_BEEF);
    ext_stall = '0;
    settle();
    chk("hold_rel_we", {31'b0, wb_rf_we}, 32'd1);
    chk("hold_rel_wdata", wb_rf_wdata, 32'hDEAD_BEEF);
    tick();
    chk("hold_after_we", {31'b0, wb_rf_we}, 32'd0);

    // Flush while waiting: the late response is dropped.
    drive_load(32'h400, 3'd0, 5'd8, 32'h0000_4000);
    tick();
    drive_nop();
    flush = 1'b1;
    settle();
    chk("flush_wait_stall", {31'b0, stallreq_mem}, 32'd1);
    tick();
    flush = 1'b0;
    settle();
    chk("drain_stallreq", {31'b0, stallreq_mem}, 32'd0);
    chk("drain_we", {31'b0, wb_rf_we}, 32'd0);
    tick();
    data_ok = 1'b1; data_rdata = 32'h1111_1111;
    settle();
    chk("drop_we", {31'b0, wb_rf_we}, 32'd0);
    chk("drop_wdata", wb_rf_wdata, 32'd0);
    tick();
    data_ok = 1'b0; data_rdata = '0;
    drive_load(32'h404, 3'd0, 5'd9, 32'h0000_5000);
    tick();
    drive_nop();
    settle();
    chk("next_ld_stall", {31'b0, stallreq_mem}, 32'd1);
    tick();
    data_ok = 1'b1; data_rdata = 32'h2222_2222;
    settle();
    chk("next_ld_we", {31'b0, wb_rf_we}, 32'd1);
    chk("next_ld_waddr", {27'b0, wb_rf_waddr}, 32'd9);
    chk("next_ld_wdata", wb_rf_wdata, 32'h2222_2222);
    tick();
    data_ok = 1'b0; data_rdata = '0;

    // Bubble clears an ALU op, then reset taken while waiting.
    drive_alu(32'h500, 5'd10, 32'h0000_0077);
    tick();
    drive_nop();
    settle();
    chk("alu_we", {31'b0, wb_rf_we}, 32'd1);
    chk("alu_wdata", wb_rf_wdata, 32'h77);
    ext_stall = 7'b0100000;
    tick();
    ext_stall = '0;
    settle();
    chk("bubble_pc", wb_pc, 32'd0);
    chk("bubble_we", {31'b0, wb_rf_we}, 32'd0);
    chk("bubble_waddr", {27'b0, wb_rf_waddr}, 32'd0);
    chk("bubble_wdata", wb_rf_wdata, 32'd0);
    drive_load(32'h504, 3'd0, 5'd11, 32'h0000_6000);
    tick();
    drive_nop();
    settle();
    chk("pre_rst_stall", {31'b0, stallreq_mem}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("wrst_stallreq", {31'b0, stallreq_mem}, 32'd0);
    chk("wrst_pc", wb_pc, 32'd0);
    chk("wrst_we", {31'b0, wb_rf_we}, 32'd0);
    chk("wrst_waddr", {27'b0, wb_rf_waddr}, 32'd0);
    chk("wrst_wdata", wb_rf_wdata, 32'd0);
    tick();
    chk("wrst_idle_stall", {31'b0, stallreq_mem}, 32'd0);

`ifdef MEM_STAGE_FWD_EN
    drive_load(32'h600, 3'd0, 5'd12, 32'h0000_7000);
    tick();
    drive_nop();
    settle();
    chk("fwd_pending", {31'b0, mem_fwd_load_pending}, 32'd1);
    chk("fwd_pending_we", {31'b0, mem_fwd_we}, 32'd0);
    tick();
    data_ok = 1'b1; data_rdata = 32'h3333_3333;
    settle();
    chk("fwd_pending_clr", {31'b0, mem_fwd_load_pending}, 32'd0);
    chk("fwd_ld_wdata", mem_fwd_wdata, 32'h3333_3333);
    tick();
    data_ok = 1'b0; data_rdata = '0;
    drive_alu(32'h604, 5'd5, 32'h0000_0042);
    tick();
    drive_nop();
    settle();
    chk("fwd_we", {31'b0, mem_fwd_we}, 32'd1);
    chk("fwd_waddr", {27'b0, mem_fwd_waddr}, 32'd5);
    chk("fwd_wdata", mem_fwd_wdata, 32'h42);
    chk("fwd_alu_pending", {31'b0, mem_fwd_load_pending}, 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the MEM pipeline stage of the 5-stage CPU.
- Registers the DC->MEM payload under the shared stall/flush protocol.
- Waits on a variable-latency data-SRAM response (data_ok) and raises a stall request while a load is outstanding.
- Buffers a response that arrives while the stage is frozen, drops a stale response after a flush, and performs byte/halfword load extraction with sign/zero extension before driving the MEM->WB bus.

Parameters:
- PC_W, 32, width of pc field.
- RF_ADDR_W, 5, register-file address width.
- STALL_W, 7, width of stall bus.
- STAGE, 5, stall-bus bit owned by this stage; bit STAGE+1 belongs to WB.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the stage contents
- stall  in  STALL_W  pipeline stall bus, 1=Stop
- pc_i  in  PC_W  instruction pc
- ram_en_i  in  1  memory access valid
- ram_wen_i  in  4  byte write enables; 0 with ram_en_i=1 means load
- load_type_i  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU, others treated as LW
- sel_rf_res_i  in  1  1=writeback memory result, 0=alu result
- rf_we_i  in  1  register write enable
- rf_waddr_i  in  RF_ADDR_W  destination register
- alu_result_i  in  32  alu result / effective address
- data_ok  in  1  SRAM read response valid, one-cycle pulse per request
- data_rdata  in  32  SRAM read data, valid with data_ok
- stallreq_mem  out  1  request to stall the pipeline at this stage
- wb_pc  out  PC_W  to WB
- wb_rf_we  out  1  to WB; forced 0 while a load is outstanding
- wb_rf_waddr  out  RF_ADDR_W  to WB
- wb_rf_wdata  out  32  to WB

Behaviour:
- Payload register, priority order:
  - rst > flush > bubble (stall[STAGE]=1 and stall[STAGE+1]=0) all clear every payload field to 0.
  - Advance when stall[STAGE]=0.
  - Otherwise hold.
- A load is captured when the payload advances with ram_en_i=1 and ram_wen_i=0.
- Response FSM, reset state IDLE:
  - IDLE: no load outstanding. A captured load -> WAIT.
  - WAIT: stallreq_mem = ~data_ok (combinational).
    - data_ok=1 and stall[STAGE]=0: data used directly. Next state is WAIT if a new load is captured the same edge, else IDLE.
    - data_ok=1 and stall[STAGE]=1: latch data_rdata into resp_buf -> HOLD.
    - flush with data_ok=0 -> DRAIN. Flush with data_ok=1 -> IDLE.
  - HOLD: wdata source is resp_buf; stallreq_mem=0. Leave on advance (-> WAIT if a new load is captured, else IDLE). Flush or bubble -> IDLE.
  - DRAIN: payload already cleared; stallreq_mem=0. The first data_ok is discarded -> IDLE, or -> WAIT if a new load is captured that same edge. A load captured before the discard: next data_ok is dropped, then WAIT is entered.
- rst from any state -> IDLE; resp_buf cleared.
- Reset values of outputs:
  - stallreq_mem=0, wb_pc=0, wb_rf_we=0, wb_rf_waddr=0, wb_rf_wdata=0.
- Extraction, with raw = selected 32-bit data and off = alu_result[1:0]:
  - LB/LBU: byte raw[8*off+:8], sign-/zero-extended.
  - LH/LHU: half raw[16*off[1]+:16], sign-/zero-extended; off[0] is ignored (misalignment is trapped upstream).
  - LW: raw.
- wb_rf_wdata = sel_rf_res ? extracted : alu_result.
- wb_rf_we = rf_we & ~(state==WAIT & ~data_ok).
- Stores: no wait, no FSM change.
- Latency: zero added cycles when data_ok arrives in the first MEM cycle.

Optional Feature:
- Macro: MEM_STAGE_FWD_EN.
- Defined: adds outputs mem_fwd_we (1), mem_fwd_waddr (RF_ADDR_W), mem_fwd_wdata (32) and mem_fwd_load_pending (1).
  - The first three equal the wb_* values.
  - mem_fwd_load_pending=1 whenever the FSM is in WAIT with data_ok=0, so ID can stall on a load-use hazard.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- LB, addr 0x1003, data_ok in the first cycle with rdata 0x80FF_1234 -> wb_rf_wdata=0xFFFF_FF80, stallreq_mem never 1.
- LHU, addr 0x2002, data_ok three cycles late with rdata 0xBEEF_0001 -> stallreq_mem=1 for 3 cycles with wb_rf_we=0 during them, then wb_rf_wdata=0x0000_BEEF.
- LW in WAIT, stall[5]=1 from another source, data_ok with 0xDEAD_BEEF -> HOLD. On release, wb_rf_wdata=0xDEAD_BEEF while data_rdata has changed to 0.
- LW in WAIT, then flush, then data_ok two cycles later with 0x1111_1111 -> response dropped, wb_rf_we=0. The next LW's response 0x2222_2222 is written.
- Bubble: stall[5]=1 and stall[6]=0 with ALU op rf_we=1 -> next cycle all wb_* =0. Then rst asserted while in WAIT -> all outputs 0, state IDLE.
- With MEM_STAGE_FWD_EN defined: a pending load asserts mem_fwd_load_pending=1. An ALU op to r5 with result 0x42 gives mem_fwd_we=1, mem_fwd_waddr=5, mem_fwd_wdata=0x42.
